// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Purpose  : Registered RV32 immediate generator for the decode stage.
//            Classifies the instruction format from the opcode, builds the
//            sign-extended immediate, and registers immediate, format code,
//            illegal flag and valid through one stall/flush-aware stage.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instruction,
    output logic [31:0] imm_out,
    output logic        imm_valid_o,
    output logic [2:0]  imm_fmt_o,
    output logic        illegal_o
);

    // Supported opcodes
    localparam logic [6:0] c_OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] c_OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] c_OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] c_OPC_JALR      = 7'b1100111;
    localparam logic [6:0] c_OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] c_OPC_STORE     = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI       = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL       = 7'b1101111;
    localparam logic [6:0] c_OPC_OP        = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_32     = 7'b0111011;

    // Format codes
    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    logic [6:0]  w_opcode;
    logic [31:0] w_imm;
    logic [2:0]  w_fmt;
    logic        w_illegal;

    logic [31:0] r_imm;
    logic [2:0]  r_fmt;
    logic        r_illegal;
    logic        r_valid;

    assign w_opcode = instruction[6:0];

    // Combinational format classification and immediate assembly
    always_comb begin
        w_imm     = 32'h0;
        w_fmt     = c_FMT_ILL;
        w_illegal = 1'b1;
        if (instruction[1:0] == 2'b11) begin
            case (w_opcode)
                c_OPC_LOAD, c_OPC_MISC_MEM, c_OPC_OP_IMM,
                c_OPC_OP_IMM_32, c_OPC_JALR, c_OPC_SYSTEM: begin
                    // Shift-immediates deliberately pass the raw I field
                    w_imm     = {{20{instruction[31]}}, instruction[31:20]};
                    w_fmt     = c_FMT_I;
                    w_illegal = 1'b0;
                end
                c_OPC_STORE: begin
                    w_imm     = {{20{instruction[31]}}, instruction[31:25],
                                 instruction[11:7]};
                    w_fmt     = c_FMT_S;
                    w_illegal = 1'b0;
                end
                c_OPC_BRANCH: begin
                    w_imm     = {{19{instruction[31]}}, instruction[31],
                                 instruction[7], instruction[30:25],
                                 instruction[11:8], 1'b0};
                    w_fmt     = c_FMT_B;
                    w_illegal = 1'b0;
                end
                c_OPC_LUI, c_OPC_AUIPC: begin
                    w_imm     = {instruction[31:12], 12'h000};
                    w_fmt     = c_FMT_U;
                    w_illegal = 1'b0;
                end
                c_OPC_JAL: begin
                    w_imm     = {{11{instruction[31]}}, instruction[31],
                                 instruction[19:12], instruction[20],
                                 instruction[30:21], 1'b0};
                    w_fmt     = c_FMT_J;
                    w_illegal = 1'b0;
                end
                c_OPC_OP, c_OPC_OP_32: begin
                    w_imm     = 32'h0;
                    w_fmt     = c_FMT_R;
                    w_illegal = 1'b0;
                end
                default: begin
                    w_imm     = 32'h0;
                    w_fmt     = c_FMT_ILL;
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    // Output stage: flush beats stall; data loads even when the word is invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm     <= 32'h0;
            r_fmt     <= c_FMT_R;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else if (flush_i) begin
            r_imm     <= 32'h0;
            r_fmt     <= c_FMT_R;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else if (!stall_i) begin
            r_imm     <= w_imm;
            r_fmt     <= w_fmt;
            r_illegal <= w_illegal;
            r_valid   <= instr_valid_i;
        end
    end

    assign imm_out     = r_imm;
    assign imm_fmt_o   = r_fmt;
    assign illegal_o   = r_illegal;
    assign imm_valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen
// Purpose  : Scoreboard bench for imm_gen using directed instruction words
//            with hand-computed immediates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic        vld;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        instr_valid_i;
    logic [31:0] instruction;
    logic [31:0] imm_out;
    logic        imm_valid_o;
    logic [2:0]  imm_fmt_o;
    logic        illegal_o;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    imm_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .instr_valid_i (instr_valid_i),
        .instruction   (instruction),
        .imm_out       (imm_out),
        .imm_valid_o   (imm_valid_o),
        .imm_fmt_o     (imm_fmt_o),
        .illegal_o     (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare current outputs against one expected record
    task automatic compare(input exp_t e);
        checks++;
        if (imm_out !== e.imm || imm_fmt_o !== e.fmt ||
            illegal_o !== e.ill || imm_valid_o !== e.vld) begin
            errors++;
            $display("FAIL %s: got imm=%h fmt=%0d ill=%b vld=%b, expected imm=%h fmt=%0d ill=%b vld=%b",
                     e.name, imm_out, imm_fmt_o, illegal_o, imm_valid_o,
                     e.imm, e.fmt, e.ill, e.vld);
        end
    endtask

    // Monitor: one expected record per loading/holding edge, checked just after it
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) compare(q.pop_front());
        end
    end

    // Drive inputs now and queue what the next edge must produce
    task automatic issue(input logic vld, input logic [31:0] ins,
                         input logic stl, input logic fls,
                         input logic [31:0] eimm, input logic [2:0] efmt,
                         input logic eill, input logic evld, input string nm);
        exp_t e;
        instr_valid_i = vld;
        instruction   = ins;
        stall_i       = stl;
        flush_i       = fls;
        e.imm = eimm; e.fmt = efmt; e.ill = eill; e.vld = evld; e.name = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic vld, input logic [31:0] ins,
                        input logic stl, input logic fls,
                        input logic [31:0] eimm, input logic [2:0] efmt,
                        input logic eill, input logic evld, input string nm);
        @(negedge clk);
        issue(vld, ins, stl, fls, eimm, efmt, eill, evld, nm);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t z;
        z.imm = 32'h0; z.fmt = 3'd0; z.ill = 1'b0; z.vld = 1'b0;

        rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        instr_valid_i = 1'b1; instruction = 32'hFFB00093;
        // Let one edge load something, then reset asynchronously between edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        z.name = "reset_async";
        compare(z);
        @(posedge clk);
        #1;
        z.name = "reset_held";
        compare(z);

        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 32'hFFB00093, 0, 0, 32'hFFFFFFFB, 3'd1, 0, 1, "addi_after_reset");
        step(1, 32'hFE50A823, 0, 0, 32'hFFFFFFF0, 3'd2, 0, 1, "sw_neg16");
        step(1, 32'h00208463, 0, 0, 32'h00000008, 3'd3, 0, 1, "beq_8");
        step(1, 32'hFE000EE3, 0, 0, 32'hFFFFFFFC, 3'd3, 0, 1, "beq_neg4");
        step(1, 32'h014000EF, 0, 0, 32'h00000014, 3'd5, 0, 1, "jal_20");
        step(1, 32'h123452B7, 0, 0, 32'h12345000, 3'd4, 0, 1, "lui");
        step(1, 32'h800002EF, 0, 0, 32'hFFF00000, 3'd5, 0, 1, "jal_min");
        step(1, 32'h0014009B, 0, 0, 32'h00000001, 3'd1, 0, 1, "op_imm_32");
        step(1, 32'h002081B3, 0, 0, 32'h00000000, 3'd0, 0, 1, "add_rtype");
        step(1, 32'h0000007F, 0, 0, 32'h00000000, 3'd7, 1, 1, "opc_7f");
        step(1, 32'h00000010, 0, 0, 32'h00000000, 3'd7, 1, 1, "low_bits_00");
        step(1, 32'hFFF00067, 0, 0, 32'hFFFFFFFF, 3'd1, 0, 1, "jalr_neg1");
        step(1, 32'h80000003, 0, 0, 32'hFFFFF800, 3'd1, 0, 1, "load_min");
        step(1, 32'h00100073, 0, 0, 32'h00000001, 3'd1, 0, 1, "ebreak");
        step(1, 32'hABCDE017, 0, 0, 32'hABCDE000, 3'd4, 0, 1, "auipc");
        step(1, 32'h7FF0F00F, 0, 0, 32'h000007FF, 3'd1, 0, 1, "fence_max");
        step(1, 32'h0000003B, 0, 0, 32'h00000000, 3'd0, 0, 1, "op_32");
        step(1, 32'hFFFFFFA3, 0, 0, 32'hFFFFFFFF, 3'd2, 0, 1, "sw_neg1");

        // Stall/flush sequence, back-to-back
        step(1, 32'h123452B7, 0, 0, 32'h12345000, 3'd4, 0, 1, "pre_stall_lui");
        step(1, 32'h002081B3, 1, 0, 32'h12345000, 3'd4, 0, 1, "stall_1");
        step(1, 32'hFE50A823, 1, 0, 32'h12345000, 3'd4, 0, 1, "stall_2");
        step(1, 32'hFE50A823, 1, 1, 32'h00000000, 3'd0, 0, 0, "stall_and_flush");
        step(1, 32'h014000EF, 0, 0, 32'h00000014, 3'd5, 0, 1, "after_release");
        step(1, 32'h0000007F, 0, 1, 32'h00000000, 3'd0, 0, 0, "flush_illegal");
        step(1, 32'h0000007F, 0, 0, 32'h00000000, 3'd7, 1, 1, "illegal_after_flush");

        // Valid gating: data still loads, valid follows instr_valid_i
        step(0, 32'hFFB00093, 0, 0, 32'hFFFFFFFB, 3'd1, 0, 0, "invalid_word");
        step(1, 32'hFFB00093, 0, 0, 32'hFFFFFFFB, 3'd1, 0, 1, "valid_again");
        drain();

        // Mid-stream reset discards the held result immediately
        @(negedge clk);
        instruction = 32'h123452B7; instr_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        z.name = "reset_midstream";
        compare(z);
        @(posedge clk);
        #1;
        z.name = "reset_midstream_held";
        compare(z);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 32'h00208463, 0, 0, 32'h00000008, 3'd3, 0, 1, "first_after_rerelease");
        drain();

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
